// File: rtl/core_mdu_sequencer.sv
// core_mdu_sequencer: multi-cycle multiply/divide sequencer for the execution stage.
// Radix-2 shift-add multiply (MUL/MULHU) and restoring divide (DIVU/REMU), one
// iteration per cycle over DATA_WIDTH cycles, with a one-cycle result pulse.
// Optional macro MDU_EARLY_OUT_EN: zero operands (multiply) or a zero divisor
// skip the iterations and complete in the cycle after accept.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// && !flush && !rst; req_ready is high in IDLE and DONE, resp_valid is a single
// cycle pulse with no back-pressure, and resp_data holds until the next result.
module core_mdu_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  stall,
  output logic [1:0]            dbg_state
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] opb_q;   // multiplicand or divisor
  logic [DATA_WIDTH-1:0] acc_hi;  // product high half / partial remainder
  logic [DATA_WIDTH-1:0] acc_lo;  // multiplier bits shifting out / quotient shifting in
  logic                  accept;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [DATA_WIDTH:0]   div_sh, div_trial;
  logic                  div_ok;
  logic [DATA_WIDTH-1:0] div_hi_nx, div_lo_nx;
  logic [DATA_WIDTH-1:0] final_res;
  logic                  early;
  logic [DATA_WIDTH-1:0] early_res;

  assign req_ready  = (state == IDLE) || (state == DONE);
  assign accept     = req_valid && req_ready && !flush && !rst;
  assign resp_valid = (state == DONE) && !flush;
  assign stall      = (state == MUL) || (state == DIV) || (accept && (state != DONE));
  assign dbg_state  = state;

  // One iteration of both datapaths from the current accumulator contents.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    mul_hi_nx = mul_sum[DATA_WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    // Remainder stays below the divisor, so DATA_WIDTH+1 bits hold the trial sign.
    div_sh    = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_trial = div_sh - {1'b0, opb_q};
    div_ok    = !div_trial[DATA_WIDTH];
    div_hi_nx = div_ok ? div_trial[DATA_WIDTH-1:0] : div_sh[DATA_WIDTH-1:0];
    div_lo_nx = {acc_lo[DATA_WIDTH-2:0], div_ok};
    case (op_q)
      2'd0:    final_res = mul_lo_nx;
      2'd1:    final_res = mul_hi_nx;
      2'd2:    final_res = div_lo_nx;
      default: final_res = div_hi_nx;
    endcase
  end

  // Zero-operand shortcut decode for the incoming request.
`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (!req_op[1]) begin
      early = (req_a == '0) || (req_b == '0);
    end else begin
      early     = (req_b == '0);
      early_res = req_op[0] ? req_a : '1;
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // Next-state logic; flush overrides everything to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (early)          state_nx = DONE;
          else if (req_op[1]) state_nx = DIV;
          else                state_nx = MUL;
        end else if (state == DONE) begin
          state_nx = IDLE;
        end
      end
      MUL, DIV: if (cnt == '0) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // State, operand latches, iteration datapath and held result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      opb_q     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= req_op;
        opb_q  <= req_b;
        acc_hi <= '0;
        acc_lo <= req_a;
        cnt    <= CNT_LAST;
        if (early) resp_data <= early_res;
      end else if (state == MUL || state == DIV) begin
        acc_hi <= (state == MUL) ? mul_hi_nx : div_hi_nx;
        acc_lo <= (state == MUL) ? mul_lo_nx : div_lo_nx;
        cnt    <= cnt - 1'b1;
        if (cnt == '0 && !flush) resp_data <= final_res;
      end
    end
  end

endmodule
